// File: rtl/host_output_schedule.sv
// host_output_schedule: two-queue (TS/BE) descriptor scheduler feeding host_tx, strict TS priority with a BE anti-starvation burst guard
// Ports:
//   i_clk, i_rst_n                      clock, asynchronous active-low reset
//   iv_descriptor, i_descriptor_*       descriptor write: 61-bit descriptor, DMAC flag, TS/BE select, write strobe
//   ov_pkt_descriptor, o_dmac_replace_flag, o_pkt_descriptor_wr   issue to host_tx (held outside ISSUE)
//   i_pkt_descriptor_ready              host_tx ready level
//   ov_ts_used, ov_be_used              queue occupancy
//   o_queue_overflow_pulse              pulses in the cycle a write to a full queue is dropped
//   ov_hos_state                        0 IDLE, 1 ISSUE, 2 HOLD
module host_output_schedule #(
    parameter int AW       = 4,
    parameter int TS_BURST = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [60:0] iv_descriptor,
    input  logic        i_descriptor_dmac_flag,
    input  logic        i_descriptor_ts,
    input  logic        i_descriptor_wr,
    output logic [60:0] ov_pkt_descriptor,
    output logic        o_dmac_replace_flag,
    output logic        o_pkt_descriptor_wr,
    input  logic        i_pkt_descriptor_ready,
    output logic [AW:0] ov_ts_used,
    output logic [AW:0] ov_be_used,
    output logic        o_queue_overflow_pulse,
    output logic [1:0]  ov_hos_state
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam int DEPTH = 1 << AW;
    localparam int BW = $clog2(TS_BURST + 2);
    localparam logic [BW-1:0] BURST_MAX = BW'(TS_BURST);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [61:0] ts_mem [DEPTH];
    logic [61:0] be_mem [DEPTH];
    logic [AW:0] ts_wr, ts_rd, be_wr, be_rd;
    logic [1:0] state;
    logic [BW-1:0] burst_cnt;
    logic ts_full, be_full, ts_ne, be_ne, push_ts, push_be, go, pick_be;

    assign ov_ts_used = ts_wr - ts_rd;
    assign ov_be_used = be_wr - be_rd;
    assign ts_full = ov_ts_used == FULL;
    assign be_full = ov_be_used == FULL;
    assign ts_ne = ov_ts_used != '0;
    assign be_ne = ov_be_used != '0;
    // full is judged on the pre-pop count, so a write to a full queue drops even if it pops this cycle
    assign push_ts = i_descriptor_wr && i_descriptor_ts && !ts_full;
    assign push_be = i_descriptor_wr && !i_descriptor_ts && !be_full;
    assign o_queue_overflow_pulse = i_descriptor_wr && (i_descriptor_ts ? ts_full : be_full);
    assign go = state == IDLE && i_pkt_descriptor_ready && (ts_ne || be_ne);
    assign pick_be = (TS_BURST != 0 && burst_cnt == BURST_MAX && be_ne) || !ts_ne;
    assign o_pkt_descriptor_wr = state == ISSUE;
    assign ov_hos_state = state;

    always_ff @(posedge i_clk) begin
        if (push_ts) ts_mem[ts_wr[AW-1:0]] <= {i_descriptor_dmac_flag, iv_descriptor};
        if (push_be) be_mem[be_wr[AW-1:0]] <= {i_descriptor_dmac_flag, iv_descriptor};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ts_wr <= '0;
            ts_rd <= '0;
            be_wr <= '0;
            be_rd <= '0;
            state <= IDLE;
            burst_cnt <= '0;
            ov_pkt_descriptor <= '0;
            o_dmac_replace_flag <= 1'b0;
        end else begin
            ts_wr <= ts_wr + (AW+1)'(push_ts);
            be_wr <= be_wr + (AW+1)'(push_be);
            ts_rd <= ts_rd + (AW+1)'(go && !pick_be);
            be_rd <= be_rd + (AW+1)'(go && pick_be);
            state <= go ? ISSUE : state == ISSUE ? HOLD : IDLE;
            if (go) {o_dmac_replace_flag, ov_pkt_descriptor} <= pick_be ? be_mem[be_rd[AW-1:0]] : ts_mem[ts_rd[AW-1:0]];
            // counts TS issues that bypass a waiting BE; an empty BE queue or a BE issue restarts the burst
            burst_cnt <= (!be_ne || (go && pick_be)) ? '0 :
                         (go && burst_cnt != BURST_MAX) ? burst_cnt + 1'b1 : burst_cnt;
        end
    end
endmodule

// File: tb/tb_host_output_schedule.sv
// tb_host_output_schedule: scoreboard bench for host_output_schedule with directed vectors
module tb_host_output_schedule;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [60:0] desc_i = '0;
    logic flag_i = 1'b0, ts_i = 1'b0, wr_i = 1'b0, ready = 1'b0;
    logic [60:0] desc_o;
    logic flag_o, wr_o, ovf;
    logic [4:0] ts_used, be_used;
    logic [1:0] st;

    int checks = 0, errors = 0, issues = 0, ovf_cnt = 0, cyc = 0, last_wr = -1;
    logic [61:0] exp_q[$];

    host_output_schedule #(.AW(4), .TS_BURST(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .iv_descriptor(desc_i), .i_descriptor_dmac_flag(flag_i), .i_descriptor_ts(ts_i), .i_descriptor_wr(wr_i),
        .ov_pkt_descriptor(desc_o), .o_dmac_replace_flag(flag_o), .o_pkt_descriptor_wr(wr_o),
        .i_pkt_descriptor_ready(ready), .ov_ts_used(ts_used), .ov_be_used(be_used),
        .o_queue_overflow_pulse(ovf), .ov_hos_state(st)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ovf) ovf_cnt++;
        if (wr_o) begin
            issues++;
            if (last_wr >= 0) chk("issue_spacing_ok", 64'(cyc - last_wr >= 3), 64'd1);
            last_wr = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got %h expected none", {flag_o, desc_o});
            end else begin
                chk("issue_desc", 64'({flag_o, desc_o}), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic put(input logic ts, input logic fl, input logic [60:0] d);
        @(posedge clk); #1;
        wr_i = 1'b1; ts_i = ts; flag_i = fl; desc_i = d;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        wr_i = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && !(exp_q.size() == 0 && st == 2'd0); k++) begin
            @(posedge clk); #2;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        logic found;
        // Test 1: reset state, then three BE descriptors with ready held
        repeat (3) @(posedge clk);
        #2;
        chk("rst_wr", 64'(wr_o), 64'd0);
        chk("rst_desc", 64'({flag_o, desc_o}), 64'd0);
        chk("rst_ts_used", 64'(ts_used), 64'd0);
        chk("rst_be_used", 64'(be_used), 64'd0);
        chk("rst_state", 64'(st), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({1'(i), 61'h100 + 61'(i)});
            put(1'b0, 1'(i), 61'h100 + 61'(i));
        end
        idle();
        drain();
        chk("t1_issues", 64'(issues), 64'd3);
        chk("t1_be_used", 64'(be_used), 64'd0);
        // Test 2: ready gating
        ready = 1'b0;
        base = issues;
        exp_q.push_back({1'b1, 61'h1_2345});
        put(1'b1, 1'b1, 61'h1_2345);
        idle();
        repeat (3) @(posedge clk);
        #2;
        chk("t2_no_issue", 64'(issues), 64'(base));
        chk("t2_ts_used", 64'(ts_used), 64'd1);
        @(posedge clk); #1;
        ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 2 && !found; k++) begin
            @(posedge clk); #1;
            found = wr_o;
        end
        chk("t2_wr_within_2", 64'(found), 64'd1);
        ready = 1'b0;
        drain();
        repeat (2) @(posedge clk);
        #2;
        chk("t2_hold_desc", 64'({flag_o, desc_o}), {3'd0, 1'b1, 61'h1_2345});
        chk("t2_hold_wr", 64'(wr_o), 64'd0);
        // Test 3: 10 TS + 2 BE -> 8 TS, BE, 2 TS, BE
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, 61'h300 + 61'(i)});
        exp_q.push_back({1'b0, 61'h400});
        exp_q.push_back({1'b1, 61'h308});
        exp_q.push_back({1'b1, 61'h309});
        exp_q.push_back({1'b0, 61'h401});
        for (int i = 0; i < 10; i++) put(1'b1, 1'b1, 61'h300 + 61'(i));
        put(1'b0, 1'b0, 61'h400);
        put(1'b0, 1'b0, 61'h401);
        idle();
        chk("t3_ts_used", 64'(ts_used), 64'd10);
        chk("t3_be_used", 64'(be_used), 64'd2);
        ready = 1'b1;
        drain();
        ready = 1'b0;
        // Test 4: 17 TS writes into a 16-deep queue
        ovf_cnt = 0;
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, 61'h500 + 61'(i)});
        for (int i = 0; i < 17; i++) put(1'b1, 1'b0, 61'h500 + 61'(i));
        idle();
        chk("t4_ts_used", 64'(ts_used), 64'd16);
        chk("t4_ovf_cnt", 64'(ovf_cnt), 64'd1);
        // Test 5: write to the full queue in the popping cycle
        @(posedge clk); #1;
        ready = 1'b1;
        wr_i = 1'b1; ts_i = 1'b1; flag_i = 1'b1; desc_i = 61'h5FF;
        idle();
        chk("t5_state", 64'(st), 64'd1);
        chk("t5_ts_used", 64'(ts_used), 64'd15);
        chk("t5_ovf_cnt", 64'(ovf_cnt), 64'd2);
        drain();
        chk("t5_ts_empty", 64'(ts_used), 64'd0);
        ready = 1'b0;
        // Test 6: reset during ISSUE
        exp_q.push_back({1'b0, 61'h600});
        exp_q.push_back({1'b0, 61'h601});
        put(1'b1, 1'b0, 61'h600);
        put(1'b1, 1'b0, 61'h601);
        idle();
        ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            @(posedge clk); #1;
            found = wr_o;
        end
        chk("t6_reached_issue", 64'(found), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_wr_async_drop", 64'(wr_o), 64'd0);
        chk("t6_ts_used", 64'(ts_used), 64'd0);
        chk("t6_state", 64'(st), 64'd0);
        exp_q.delete();
        base = issues;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        chk("t6_no_stale_issue", 64'(issues), 64'(base));
        chk("end_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
